// File: rtl/axi_rd_mux_rr.sv
// N-to-1 AXI read-channel mux: round-robin AR arbitration with per-requester
// outstanding-burst limits; R beats are routed back by the index prepended to the ID.

module axi_rd_mux_rr_cnt #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic uflow_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] cnt_q;

  // A grant and a completion in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign full_o  = (cnt_q >= CW'(MAX_OUTSTANDING));
  assign uflow_o = dec_i && (cnt_q == '0);
endmodule

module axi_rd_mux_rr #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int REQ_ID_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int ID_W           = REQ_ID_WIDTH + IDX_W
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*REQ_ID_WIDTH-1:0] req_id_i,
  input  logic [NUM_REQ*8-1:0]            req_len_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  input  logic [NUM_REQ-1:0]              rsp_ready_i,
  output logic [DATA_WIDTH-1:0]           rsp_data_o,
  output logic [REQ_ID_WIDTH-1:0]         rsp_id_o,
  output logic                            rsp_last_o,
  output logic [1:0]                      rsp_resp_o,
  output logic                            ar_valid_o,
  input  logic                            ar_ready_i,
  output logic [ADDR_WIDTH-1:0]           ar_addr_o,
  output logic [ID_W-1:0]                 ar_id_o,
  output logic [7:0]                      ar_len_o,
  input  logic                            r_valid_i,
  output logic                            r_ready_o,
  input  logic [DATA_WIDTH-1:0]           r_data_i,
  input  logic [ID_W-1:0]                 r_id_i,
  input  logic                            r_last_i,
  input  logic [1:0]                      r_resp_i,
  output logic                            err_o
);
  logic                    ar_valid_q;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic [ID_W-1:0]         ar_id_q;
  logic [7:0]              ar_len_q;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    err_q;

  logic                    slot_free;
  logic [NUM_REQ-1:0]      full, uflow, done, elig, gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    found;
  int                      cand, win;

  logic [IDX_W-1:0]        r_idx;
  logic                    idx_ok;
  logic                    r_hs;
  logic                    err_set;

  assign slot_free = !ar_valid_q || ar_ready_i;
  assign elig      = req_valid_i & ~full;

  // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    cand     = 0;
    win      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (slot_free && !found && elig[cand]) begin
        found     = 1'b1;
        win       = cand;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
        rr_ptr_d  = IDX_W'((cand + 1) % NUM_REQ);
      end
    end
  end

  assign req_ready_o = gnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (found) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
        ar_id_q    <= {gnt_idx, req_id_i[win*REQ_ID_WIDTH +: REQ_ID_WIDTH]};
        ar_len_q   <= req_len_i[win*8 +: 8];
      end else if (ar_ready_i) begin
        ar_valid_q <= 1'b0;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = ar_addr_q;
  assign ar_id_o    = ar_id_q;
  assign ar_len_o   = ar_len_q;
  assign err_o      = err_q;

  // R path: purely combinational demux keyed by the ID's index field.
  assign r_idx = r_id_i[ID_W-1 -: IDX_W];

  generate
    if (NUM_REQ == (1 << IDX_W)) begin : g_idx_pow2
      assign idx_ok = 1'b1;
    end else begin : g_idx_chk
      assign idx_ok = (r_idx < IDX_W'(NUM_REQ));
    end
  endgenerate

  always_comb begin
    rsp_valid_o = '0;
    r_ready_o   = !idx_ok;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx_ok && (r_idx == IDX_W'(k))) begin
        rsp_valid_o[k] = r_valid_i;
        r_ready_o      = rsp_ready_i[k];
      end
    end
  end

  assign r_hs       = r_valid_i && r_ready_o;
  assign rsp_data_o = r_data_i;
  assign rsp_id_o   = r_id_i[REQ_ID_WIDTH-1:0];
  assign rsp_last_o = r_last_i;
  assign rsp_resp_o = r_resp_i;

  always_comb begin
    done = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      done[k] = r_hs && r_last_i && idx_ok && (r_idx == IDX_W'(k));
    end
  end

  assign err_set = (|uflow) || (r_valid_i && !idx_ok);

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
      axi_rd_mux_rr_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
      ) u_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (gnt[k]),
        .dec_i   (done[k]),
        .full_o  (full[k]),
        .uflow_o (uflow[k])
      );
    end
  endgenerate
endmodule

// File: tb/tb_axi_rd_mux_rr.sv
// Directed bench for axi_rd_mux_rr: a 4-requester instance (limit 2) and a
// 3-requester instance for the out-of-range index path.

module tb_axi_rd_mux_rr;
  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int MO = 2;
  localparam int IW = 6;

  logic clk, rstn;

  logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*RW-1:0] req_id;
  logic [NR*8-1:0]  req_len;
  logic [DW-1:0]    rsp_data, r_data;
  logic [RW-1:0]    rsp_id;
  logic             rsp_last, r_last;
  logic [1:0]       rsp_resp, r_resp;
  logic             ar_valid, ar_ready, r_valid, r_ready, err;
  logic [AW-1:0]    ar_addr;
  logic [IW-1:0]    ar_id, r_id;
  logic [7:0]       ar_len;

  logic [2:0]       b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [DW-1:0]    b_rsp_data;
  logic [RW-1:0]    b_rsp_id;
  logic             b_rsp_last, b_ar_valid, b_r_valid, b_r_ready, b_err;
  logic [1:0]       b_rsp_resp;
  logic [AW-1:0]    b_ar_addr;
  logic [IW-1:0]    b_ar_id, b_r_id;
  logic [7:0]       b_ar_len;

  int n_chk  = 0;
  int n_pass = 0;

  axi_rd_mux_rr #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .REQ_ID_WIDTH(RW), .MAX_OUTSTANDING(MO)) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_id_i(req_id), .req_len_i(req_len),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .rsp_last_o(rsp_last), .rsp_resp_o(rsp_resp),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
    .ar_id_o(ar_id), .ar_len_o(ar_len),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data),
    .r_id_i(r_id), .r_last_i(r_last), .r_resp_i(r_resp),
    .err_o(err)
  );

  axi_rd_mux_rr #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .REQ_ID_WIDTH(RW), .MAX_OUTSTANDING(MO)) u_dut3 (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(3'b000), .req_ready_o(b_req_ready),
    .req_addr_i('0), .req_id_i('0), .req_len_i('0),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_data_o(b_rsp_data), .rsp_id_o(b_rsp_id), .rsp_last_o(b_rsp_last), .rsp_resp_o(b_rsp_resp),
    .ar_valid_o(b_ar_valid), .ar_ready_i(1'b1), .ar_addr_o(b_ar_addr),
    .ar_id_o(b_ar_id), .ar_len_o(b_ar_len),
    .r_valid_i(b_r_valid), .r_ready_o(b_r_ready), .r_data_i(32'h0),
    .r_id_i(b_r_id), .r_last_i(1'b1), .r_resp_i(2'b00),
    .err_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic r_beat(input logic v, input logic [IW-1:0] id, input logic last,
                        input logic [NR-1:0] rdy);
    r_valid   = v;
    r_id      = id;
    r_last    = last;
    rsp_ready = rdy;
  endtask

  initial begin
    rstn = 1'b0; ar_ready = 1'b0; req_valid = '0; rsp_ready = '0;
    r_valid = 1'b0; r_id = '0; r_last = 1'b0; r_data = '0; r_resp = '0;
    b_r_valid = 1'b0; b_r_id = '0; b_rsp_ready = '0;
    for (int k = 0; k < NR; k++) begin
      req_addr[k*AW +: AW] = AW'(16'h1000 + k * 16'h0100);
      req_id[k*RW +: RW]   = RW'(k + 1);
      req_len[k*8 +: 8]    = 8'(k);
    end
    step(); step();

    // Reset state
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_ar_addr", ar_addr, 0);
    chk("rst_ar_id", ar_id, 0);
    chk("rst_ar_len", ar_len, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;
    step();

    // Round-robin with everyone requesting: 0,1,2,3,0
    ar_ready = 1'b1; req_valid = 4'hF; #1;
    chk("rr_rdy0", req_ready, 4'b0001);
    step();
    chk("rr_ar_id0", ar_id, {2'd0, 4'd1});
    chk("rr_ar_addr0", ar_addr, 16'h1000);
    chk("rr_rdy1", req_ready, 4'b0010);
    step();
    chk("rr_ar_valid1", ar_valid, 1);
    chk("rr_ar_id1", ar_id, {2'd1, 4'd2});
    chk("rr_ar_len1", ar_len, 1);
    chk("rr_rdy2", req_ready, 4'b0100);
    step();
    chk("rr_ar_id2", ar_id, {2'd2, 4'd3});
    chk("rr_ar_addr2", ar_addr, 16'h1200);
    chk("rr_rdy3", req_ready, 4'b1000);
    step();
    chk("rr_ar_id3", ar_id, {2'd3, 4'd4});
    chk("rr_rdy0b", req_ready, 4'b0001);
    step();
    chk("rr_ar_id0b", ar_id, {2'd0, 4'd1});
    req_valid = '0;
    step();
    chk("rr_drain", ar_valid, 0);
    do_reset();

    // Downstream stall with requester 2 in the slot
    req_valid = 4'b0100; #1;
    chk("st_rdy2", req_ready, 4'b0100);
    step();
    ar_ready = 1'b0; req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("st_valid", ar_valid, 1);
      chk("st_id", ar_id, {2'd2, 4'd3});
      chk("st_no_rdy", req_ready, 0);
      step();
    end
    ar_ready = 1'b1; #1;
    chk("st_rdy3", req_ready, 4'b1000);
    step();
    chk("st_ar_id3", ar_id, {2'd3, 4'd4});
    req_valid = '0;
    step();
    do_reset();

    // Outstanding limit of 2 on requester 1
    req_valid = 4'b0010; #1;
    chk("lim_rdy1a", req_ready, 4'b0010);
    step();
    chk("lim_rdy1b", req_ready, 4'b0010);
    step();
    req_valid = 4'b0111; #1;
    chk("lim_rdy2", req_ready, 4'b0100);
    step();
    chk("lim_rdy0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0010;
    r_beat(1'b1, {2'd1, 4'd3}, 1'b1, 4'b0010); #1;
    chk("lim_blocked", req_ready, 0);
    chk("lim_rsp_valid", rsp_valid, 4'b0010);
    chk("lim_r_ready", r_ready, 1);
    step();
    r_beat(1'b0, '0, 1'b0, '0); #1;
    chk("lim_unblock", req_ready, 4'b0010);
    req_valid = '0;
    step();

    // R routing by index
    r_data = 32'hDEADBEEF; r_resp = 2'd2;
    r_beat(1'b1, {2'd3, 4'h5}, 1'b0, 4'b1000); #1;
    chk("rt_rsp_valid", rsp_valid, 4'b1000);
    chk("rt_rsp_id", rsp_id, 5);
    chk("rt_r_ready", r_ready, 1);
    chk("rt_data", rsp_data, 32'hDEADBEEF);
    chk("rt_resp", rsp_resp, 2);
    chk("rt_last", rsp_last, 0);
    rsp_ready = 4'b0111; #1;
    chk("rt_r_ready_lo", r_ready, 0);
    chk("rt_rsp_valid_hold", rsp_valid, 4'b1000);
    r_beat(1'b0, '0, 1'b0, '0);
    step();
    chk("rt_no_err", err, 0);
    do_reset();

    // Same-cycle grant and completion on requester 0
    req_valid = 4'b0001; #1;
    chk("sc_rdy_first", req_ready, 4'b0001);
    step();
    r_beat(1'b1, {2'd0, 4'd1}, 1'b1, 4'b0001); #1;
    chk("sc_rdy_same", req_ready, 4'b0001);
    chk("sc_r_ready", r_ready, 1);
    step();
    r_beat(1'b0, '0, 1'b0, '0); #1;
    chk("sc_rdy_cnt1", req_ready, 4'b0001);
    step();
    chk("sc_blocked_cnt2", req_ready, 0);
    chk("sc_no_err", err, 0);
    req_valid = '0;
    r_beat(1'b1, {2'd2, 4'd0}, 1'b1, 4'b0100); #1;
    chk("uf_err_before", err, 0);
    step();
    r_beat(1'b0, '0, 1'b0, '0);
    chk("uf_err_set", err, 1);
    step(); step();
    chk("uf_err_sticky", err, 1);

    // NUM_REQ=3: index 3 is dropped and flagged
    b_r_id = {2'd2, 4'd7}; b_rsp_ready = 3'b100; b_r_valid = 1'b1; #1;
    chk("b3_legal_valid", b_rsp_valid, 3'b100);
    chk("b3_legal_ready", b_r_ready, 1);
    b_r_valid = 1'b0; b_rsp_ready = 3'b000;
    step();
    b_r_id = {2'd3, 4'd1}; b_r_valid = 1'b1; #1;
    chk("b3_ill_ready", b_r_ready, 1);
    chk("b3_ill_valid", b_rsp_valid, 0);
    chk("b3_err_before", b_err, 0);
    step();
    b_r_valid = 1'b0;
    chk("b3_err_set", b_err, 1);
    step(); step();
    chk("b3_err_sticky", b_err, 1);
    do_reset();
    chk("b3_err_clr", b_err, 0);
    chk("uf_err_clr", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_rd_mux_rr.md
# axi_rd_mux_rr

Parametrised N-to-1 AXI read-channel multiplexer for the core tile. It merges `NUM_REQ` independent read requesters (iCache refill, dCache miss, uncached read, future prefetcher/PTW) onto one AR/R channel pair that feeds the atomics adapter. Requesters are granted in round-robin order. A per-requester limit caps outstanding bursts. The requester index is prepended to each ID, and returning R beats are routed back by ID.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `ADDR_WIDTH`, 64: AR address width.
- `DATA_WIDTH`, 512: R data width.
- `REQ_ID_WIDTH`, 4: requester-side ID width.
- `MAX_OUTSTANDING`, 4: maximum accepted-but-not-completed bursts per requester; legal range 1..15.
- Derived `IDX_W` = max(1, clog2(NUM_REQ)); `ID_W` = `REQ_ID_WIDTH` + `IDX_W`.

Ports:
- `clk_i`  in  1  single clock domain.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester read request valid.
- `req_ready_o`  out  NUM_REQ  per-requester grant (ready).
- `req_addr_i`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k occupies slice k.
- `req_id_i`  in  NUM_REQ*REQ_ID_WIDTH  packed IDs.
- `req_len_i`  in  NUM_REQ*8  packed AXI burst lengths (beats-1).
- `rsp_valid_o`  out  NUM_REQ  per-requester R beat valid.
- `rsp_ready_i`  in  NUM_REQ  per-requester R beat ready.
- `rsp_data_o`  out  DATA_WIDTH  R data, shared by all requesters.
- `rsp_id_o`  out  REQ_ID_WIDTH  original requester ID, shared.
- `rsp_last_o`  out  1  last beat, shared.
- `rsp_resp_o`  out  2  AXI RRESP, shared.
- `ar_valid_o`, `ar_ready_i`, `ar_addr_o` (ADDR_WIDTH), `ar_id_o` (ID_W), `ar_len_o` (8): downstream AR channel.
- `r_valid_i`, `r_ready_o`, `r_data_i` (DATA_WIDTH), `r_id_i` (ID_W), `r_last_i`, `r_resp_i` (2): downstream R channel.
- `err_o`  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- The AR output is a single registered slot. The slot is free when `!ar_valid_o` or `ar_valid_o && ar_ready_i`.
- Eligibility: requester k is eligible when `req_valid_i[k]` is set and `cnt[k] < MAX_OUTSTANDING`.
- Arbitration runs only when the slot is free. The winner is the first eligible index at or after `rr_ptr`, searching upward modulo `NUM_REQ`.
- `req_ready_o` is one-hot for the winner and all-zero otherwise. It depends combinationally on `req_valid_i`, the counters and `ar_ready_i`.
- On a grant:
  - The slot loads `addr`, `len` and `{k[IDX_W-1:0], req_id}`.
  - `rr_ptr` becomes (k+1) mod `NUM_REQ`.
  - `cnt[k]` increments.
- With no grant, `rr_ptr` holds.
- R routing is combinational:
  - `idx = r_id_i[ID_W-1 -: IDX_W]`.
  - `rsp_valid_o[idx] = r_valid_i`; all other bits are 0.
  - `r_ready_o = rsp_ready_i[idx]`.
  - Shared response fields pass through, with `rsp_id_o = r_id_i[REQ_ID_WIDTH-1:0]`.
- Illegal index (`idx >= NUM_REQ`, possible only when NUM_REQ is not a power of two):
  - `r_ready_o = 1` and the beat is dropped.
  - No `rsp_valid_o` bit is asserted.
  - `err_o` is set.
- Completion: a handshake with `r_last_i` decrements `cnt[idx]`.
  - If `cnt[idx]` is already 0, it stays 0 and `err_o` is set.
- A grant and a completion on the same requester in the same cycle leave `cnt` unchanged.
- The block does not reorder beats. Per-ID ordering is the downstream's responsibility.

## Timing
- Reset values: `ar_valid_o`=0, `ar_addr_o`/`ar_id_o`/`ar_len_o`=0, `req_ready_o`=0, `rr_ptr`=0, all `cnt`=0, `err_o`=0. `rsp_valid_o` and `r_ready_o` follow the combinational equations, so they are 0 while `r_valid_i`/`rsp_ready_i` are 0.
- AR latency: a request handshake at edge t gives `ar_valid_o`=1 after edge t; the AR is presented in cycle t+1.
- Throughput: one AR per cycle while `ar_ready_i`=1. A new grant may occur in the same cycle the slot drains.
- While `ar_valid_o`=1 and `ar_ready_i`=0, the AR fields are stable and no `req_ready_o` is asserted.
- R path latency is 0 cycles, with no buffering.
- Reset mid-operation:
  - The slot and counters clear immediately.
  - Any R beats still in flight after reset are routed normally.
  - Their `r_last` handshakes on zero counters set `err_o`.
- Counter width is clog2(`MAX_OUTSTANDING`+1). Counters never exceed `MAX_OUTSTANDING`.

## Test plan
- NUM_REQ=4, `ar_ready_i`=1, all requesters valid continuously → grants cycle 0,1,2,3,0. `ar_id_o` upper 2 bits follow the same sequence, with one AR per cycle.
- `ar_ready_i`=0 for 5 cycles with requester 2 pending → `ar_valid_o` is held with `ar_id_o`={2'd2, id} and no `req_ready_o` during the stall. After the stall, requester 3 is granted in the next cycle.
- MAX_OUTSTANDING=2, requester 1 issues 2 bursts and receives no R beats → its third request is blocked (`req_ready_o[1]`=0) while requesters 0/2 are still granted. One `r_last` on ID {1,x} unblocks it the next cycle.
- R beat with `r_id_i`={2'd3, 4'h5} and `rsp_ready_i`=4'b1000 → `rsp_valid_o`=4'b1000, `rsp_id_o`=5, `r_ready_o`=1. With `rsp_ready_i[3]`=0 → `r_ready_o`=0.
- NUM_REQ=3, R beat with index 3 → `r_ready_o`=1, `rsp_valid_o`=0, `err_o` rises and stays 1 until `rstn_i` is asserted.
- Same-cycle grant to requester 0 with a `r_last` completion for requester 0 at `cnt`=1 → `cnt[0]` remains 1. A later `r_last` on requester 2 at `cnt`=0 sets `err_o`.
